seq_multiplier: RTL and testbench

//   Parametrised sequential shift-and-add multiplier, successor to the 2x2 array multiplier.
//   - Multiplies two WIDTH-bit operands, unsigned or two's-complement, selected per operation.
//   - Computes one partial product per clock, so area grows linearly with WIDTH, not quadratically.
//   - Sits beside the ALU; control logic issues start and waits for the done pulse.

---
 rtl/mult_pkg.sv | 17 +
 rtl/seq_multiplier_adder.sv | 54 +++++
 rtl/seq_multiplier.sv | 120 ++++++++++++
 tb/tb_seq_multiplier.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier.
//   mult_state_t : controller states (IDLE -> CALC -> DONE -> IDLE)
//   clog2        : ceiling log2 with a floor of 1, used to size the bit counter
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_adder.sv
// Ripple-carry adder used by the multiplier's partial-product step.
//   half_adder : a, b -> sum, cout
//   full_adder : a, b, cin -> sum, cout (two half adders plus carry OR)
//   adder_nbit : N-bit ripple adder; a, b, cin -> sum[N-1:0], cout
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .cout(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .cout(c1));

  assign cout = c0 | c1;
endmodule

module adder_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[N];
endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one partial product per clock.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   start      : request, accepted only in IDLE
//   is_signed  : 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b       : WIDTH-bit multiplicand / multiplier (sampled with start)
//   p          : 2*WIDTH-bit product, held until the next result is written
//   busy       : high while the WIDTH calculation cycles run
//   done       : one-cycle pulse when p becomes valid
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Magnitude of a two's-complement operand; -2^(WIDTH-1) maps to 2^(WIDTH-1),
  // which is representable as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  mult_state_t        state;
  logic [WIDTH-1:0]   mcand;
  // Upper half accumulates partial products; lower half starts as the
  // multiplier and is consumed from its LSB as product bits shift in.
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] acc_next;

  assign addend = acc[0] ? mcand : '0;

  adder_nbit #(.N(WIDTH)) u_add (
    .a   (acc[2*WIDTH-1:WIDTH]),
    .b   (addend),
    .cin (1'b0),
    .sum (sum),
    .cout(carry)
  );

  // The carry re-enters at the top as {carry, sum, multiplier} shifts right.
  assign acc_next = {carry, sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (is_signed) begin
              mcand <= magnitude(a);
              acc   <= {{WIDTH{1'b0}}, magnitude(b)};
              neg   <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
              mcand <= a;
              acc   <= {{WIDTH{1'b0}}, b};
              neg   <= 1'b0;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end

        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            p     <= neg ? negate(acc_next) : acc_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start4, sgn4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       busy4, done4;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        busy8, done8;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .is_signed(sgn4),
    .a(a4), .b(b4), .p(p4), .busy(busy4), .done(done4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .p(p8), .busy(busy8), .done(done8)
  );

  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x, y;
    x = int'(a);
    y = int'(b);
    if (s && a[3]) x -= 16;
    if (s && b[3]) y -= 16;
    return 8'(x * y);
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y;
    x = int'(a);
    y = int'(b);
    if (s && a[7]) x -= 256;
    if (s && b[7]) y -= 256;
    return 16'(x * y);
  endfunction

  // One operation on the WIDTH=4 instance: pulse start, scramble inputs after
  // acceptance, expect done exactly 5 cycles later and p from the scoreboard.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, input string name);
    int n;
    bit got;
    logic [7:0] exp;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = a; b4 = b; sgn4 = s;
    q4.push_back(model4(a, b, s));
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); sgn4 = 1'($urandom);
    n = 1;
    got = 0;
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL %s busy after start: got %b want 1", name, busy4);
    end
    while (!got && n <= 20) begin
      if (done4 === 1'b1) got = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    exp = q4.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done timeout: got none want done at cycle 5", name);
    end else if (n != 5) begin
      errors++;
      $display("FAIL %s done latency: got %0d want 5", name, n);
    end
    if (got) begin
      checks++;
      if (p4 !== exp || busy4 !== 1'b0) begin
        errors++;
        $display("FAIL %s product: got p=%h busy=%b want p=%h busy=0", name, p4, busy4, exp);
      end
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n;
    bit got;
    logic [15:0] exp;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = a; b8 = b; sgn8 = s;
    q8.push_back(model8(a, b, s));
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    n = 1;
    got = 0;
    while (!got && n <= 30) begin
      if (done8 === 1'b1) got = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    exp = q8.pop_front();
    checks++;
    if (!got || n != 9) begin
      errors++;
      $display("FAIL w8 latency a=%h b=%h s=%b: got %0d (done seen %b) want 9", a, b, s, n, got);
    end
    if (got) begin
      checks++;
      if (p8 !== exp) begin
        errors++;
        $display("FAIL w8 product a=%h b=%h s=%b: got %h want %h", a, b, s, p8, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (p4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0 || p8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset state: got p4=%h busy4=%b done4=%b p8=%h busy8=%b done8=%b want all zero",
               p4, busy4, done4, p8, busy8, done8);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    op4(4'd3, 4'd2, 1'b0, "u_3x2");
    op4(4'd15, 4'd15, 1'b0, "u_15x15");
    op4(4'd0, 4'd9, 1'b0, "u_0x9");
    op4(4'd9, 4'd0, 1'b0, "u_9x0");
  endtask

  task automatic test_signed();
    op4(4'hD, 4'd5, 1'b1, "s_m3x5");
    op4(4'h8, 4'h8, 1'b1, "s_m8xm8");
    op4(4'h8, 4'd7, 1'b1, "s_m8x7");
    op4(4'hF, 4'hF, 1'b1, "s_m1xm1");
  endtask

  task automatic test_start_held();
    int dones;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd2; b4 = 4'd3; sgn4 = 1'b0;
    q4.push_back(model4(4'd2, 4'd3, 1'b0));
    dones = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin
        a4 = 4'd7; b4 = 4'd7;
      end
      if (done4 === 1'b1) dones++;
      if (n == 5) start4 = 1'b0;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL start_held done count: got %0d want 1", dones);
    end
    checks++;
    begin
      logic [7:0] exp;
      exp = q4.pop_front();
      if (p4 !== exp) begin
        errors++;
        $display("FAIL start_held product: got %h want %h", p4, exp);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    int dones;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd3; sgn4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (p4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_calc reset: got p=%h busy=%b done=%b want p=00 busy=0 done=0", p4, busy4, done4);
    end
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done4 !== 1'b0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_calc stray done: got %0d want 0", dones);
    end
    op4(4'd5, 4'd3, 1'b0, "after_reset_5x3");
  endtask

  task automatic test_exhaustive4();
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op4(4'(x), 4'(y), 1'(s), "w4_sweep");
  endtask

  task automatic test_sweep8();
    op8(8'h00, 8'h00, 1'b0);
    op8(8'hFF, 8'hFF, 1'b0);
    op8(8'h80, 8'h80, 1'b1);
    op8(8'h80, 8'h7F, 1'b1);
    op8(8'hFF, 8'h01, 1'b1);
    op8(8'h7F, 8'h7F, 1'b1);
    for (int i = 0; i < 600; i++)
      op8(8'($urandom), 8'($urandom), 1'(i & 1));
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_start_held();
    test_reset_mid_calc();
    test_exhaustive4();
    test_sweep8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
